// File: rtl/divider.sv
// rtl/divider.sv - 64-bit signed restoring divider, one quotient bit per clock
module divider (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        op_done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [6:0]  cnt;
    logic [64:0] prem;
    logic [63:0] qreg;
    logic [63:0] dmag;
    logic        neg_q, neg_r, dz;

    // One extra headroom bit so the sign of the trial subtraction is exact.
    logic [65:0] trial;
    logic        fits;

    assign trial = {prem, qreg[63]} - {2'b00, dmag};
    assign fits  = ~trial[65];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op_start) next_state = EXEC;
            EXEC:    if (dz || cnt == 7'd64) next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (op_clear) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            prem        <= '0;
            qreg        <= '0;
            dmag        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (op_clear) begin
            cnt         <= '0;
            prem        <= '0;
            qreg        <= '0;
            dmag        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            op_done     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (op_start) begin
                    neg_q <= dividend[63] ^ divisor[63];
                    neg_r <= dividend[63];
                    cnt   <= '0;
                    prem  <= '0;
                    dz    <= (divisor == 64'd0);
                    dmag  <= divisor[63] ? -divisor : divisor;
                    // A zero divisor keeps the raw dividend to report as remainder.
                    if (divisor == 64'd0) qreg <= dividend;
                    else                  qreg <= dividend[63] ? -dividend : dividend;
                end
                EXEC: begin
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= qreg;
                        div_by_zero <= 1'b1;
                        op_done     <= 1'b1;
                    end else if (cnt == 7'd64) begin
                        quotient  <= neg_q ? -qreg : qreg;
                        remainder <= neg_r ? -prem[63:0] : prem[63:0];
                        op_done   <= 1'b1;
                    end else begin
                        prem <= fits ? trial[64:0] : {prem[63:0], qreg[63]};
                        qreg <= {qreg[62:0], fits};
                        cnt  <= cnt + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model
module tb_divider;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_start = 1'b0;
    logic        op_clear = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic [63:0] quotient, remainder;
    logic        op_done, div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .op_done     (op_done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating signed division as plain arithmetic, with the two special cases.
    task automatic model(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output logic z);
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 64'd0) begin
            q = '1; r = a; z = 1'b1;
        end else if (a == MIN64 && b == '1) begin
            q = MIN64; r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_q"},    quotient, '0);
        check({tag, "_r"},    remainder, '0);
        check({tag, "_done"}, {63'd0, op_done}, 64'd0);
        check({tag, "_dz"},   {63'd0, div_by_zero}, 64'd0);
    endtask

    task automatic clear_op(input string tag);
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        check_zero({tag, "_clr"});
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    // Start, count edges to op_done, check result, check hold in DONE, then clear.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input string tag);
        logic [63:0] eq, er;
        logic        ez;
        int          edges;
        model(a, b, eq, er, ez);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 30 && !ez) check({tag, "_execq"}, quotient, '0);
        end while (!op_done && edges < 200);
        check({tag, "_lat"}, 64'(edges), ez ? 64'd1 : 64'd65);
        check({tag, "_q"},  quotient, eq);
        check({tag, "_r"},  remainder, er);
        check({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, ez});
        @(negedge clk);
        op_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_done"}, {63'd0, op_done}, 64'd1);
        check({tag, "_hold_q"},    quotient, eq);
        check({tag, "_hold_r"},    remainder, er);
        clear_op(tag);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          edges;
        logic [63:0] eq, er;
        logic        ez;

        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        do_op(64'hFFFF_FFFF_FFFF_FD44, 64'd100, "m700_100");
        do_op(64'd18, 64'd3, "18_3");
        do_op(64'd20, -64'd6, "20_m6");
        do_op(-64'd20, 64'd6, "m20_6");
        do_op(64'd5, 64'd0, "5_0");
        do_op(MIN64, '1, "min_m1");
        do_op(MIN64, 64'd3, "min_3");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, MIN64, "max_min");

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        dividend = 64'hFFFF_FFFF_FFFF_FD44;
        divisor  = 64'd100;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("rst_exec");
        repeat (70) @(posedge clk);
        #1;
        check({"rst_hold", "_done"}, {63'd0, op_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(64'd100, 64'd7, "100_7");

        // Asynchronous reset while DONE holds a nonzero result.
        @(negedge clk);
        dividend = 64'd5;
        divisor  = 64'd0;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done_pre_dz", {63'd0, div_by_zero}, 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rst_done");
        @(negedge clk);
        reset_n = 1'b1;

        // op_clear on edge 40 of EXEC with op_start held high restarts next edge.
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd9;
        op_start = 1'b1;
        @(posedge clk);
        repeat (39) @(posedge clk);
        @(negedge clk);
        op_clear = 1'b1;
        dividend = -64'd12345;
        divisor  = 64'd77;
        @(posedge clk);
        #1;
        check_zero("clr40");
        @(negedge clk);
        op_clear = 1'b0;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        model(-64'd12345, 64'd77, eq, er, ez);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!op_done && edges < 200);
        check("clr40_lat", 64'(edges), 64'd65);
        check("clr40_q", quotient, eq);
        check("clr40_r", remainder, er);
        clear_op("clr40");

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case (i % 4)
                1: rb = 64'(signed'($urandom_range(0, 40)) - 20);
                2: begin
                    ra = 64'(signed'($urandom_range(0, 2000)) - 1000);
                    rb = 64'(signed'($urandom_range(1, 60)) - 30);
                end
                3: rb = {32'd0, $urandom} >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(ra, rb, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge clock, single clock domain.
REQ-002 The block SHALL have ports: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: op_start  input  1  start request, level-sampled at clk rise.
REQ-004 The block SHALL have ports: op_clear  input  1  synchronous clear/acknowledge.
REQ-005 The block SHALL have ports: dividend  input  64  signed two's-complement dividend.
REQ-006 The block SHALL have ports: divisor  input  64  signed two's-complement divisor.
REQ-007 The block SHALL have ports: quotient  output  64  signed quotient, registered.
REQ-008 The block SHALL have ports: remainder  output  64  signed remainder, registered.
REQ-009 The block SHALL have ports: op_done  output  1  result valid, registered.
REQ-010 The block SHALL have ports: div_by_zero  output  1  divisor-was-zero flag, registered.

Function
REQ-011 The FSM SHALL have states IDLE, EXEC, DONE; reset state IDLE.
REQ-012 In IDLE with op_start=1 and op_clear=0 at a clk edge, the block SHALL latch dividend/divisor and record their signs; later input changes SHALL be ignored until the next IDLE.
REQ-013 At that edge, if divisor /= 0, the block SHALL convert both operands to 64-bit unsigned magnitudes, zero a 7-bit iteration counter and a 65-bit partial remainder, and enter EXEC.
REQ-014 In EXEC, each edge SHALL perform one restoring step: shift {partial remainder, quotient} left 1, subtract divisor magnitude, set quotient LSB=1 and keep the difference if non-negative, else restore and set LSB=0.
REQ-015 After the 64th EXEC step, the next edge SHALL apply sign correction and enter DONE with op_done=1, i.e. op_done rises exactly 65 edges after the start edge.
REQ-016 Sign correction SHALL negate the quotient when the operand signs differ and give the remainder the dividend's sign, i.e. truncate toward zero with dividend = quotient*divisor + remainder.
REQ-017 The magnitude of 64'h8000_0000_0000_0000 SHALL be handled as unsigned 2^63; 64'h8000_0000_0000_0000 / -1 SHALL wrap to quotient 64'h8000_0000_0000_0000, remainder 0, with no flag.
REQ-018 If divisor = 0 at the start edge, the block SHALL go directly to DONE on the next edge with quotient 64'hFFFF_FFFF_FFFF_FFFF, remainder = latched dividend, div_by_zero=1, op_done=1.
REQ-019 quotient/remainder SHALL hold 0 during EXEC and update only on entry to DONE; op_done, quotient, remainder and div_by_zero SHALL be held stable in DONE until op_clear.
REQ-020 In DONE, op_start SHALL be ignored; op_start=1 with op_clear=0 SHALL NOT restart.
REQ-021 op_clear=1 at any edge in any state SHALL force IDLE, abort any EXEC in progress, and zero quotient, remainder, op_done and div_by_zero.
REQ-022 When op_start and op_clear are both 1 at the same edge, op_clear SHALL win; if op_start is still 1 at the following edge, a new operation SHALL start from IDLE.
REQ-023 After a completed operation and op_clear, a level-high op_start SHALL begin the next operation with the operands present at that edge.

Reset
REQ-024 reset_n=0 SHALL immediately, without waiting for a clk edge, force IDLE, zero all outputs, the counter and the internal registers, including mid-EXEC.
REQ-025 After reset_n rises, the block SHALL accept op_start at the first following clk edge.

Verification
REQ-026 The bench SHALL cover: dividend -700 (64'hFFFF_FFFF_FFFF_FD44), divisor 100 -> quotient 64'hFFFF_FFFF_FFFF_FFF9, remainder 0, op_done high 65 edges after start and held until op_clear.
REQ-027 The bench SHALL cover: 18/3 and 20/-6, then -20/6 with op_clear between each -> quotients 6, 64'h...FFFD, 64'h...FFFD; remainders 0, 2, 64'h...FFFE.
REQ-028 The bench SHALL cover: 5/0 -> div_by_zero=1, quotient all ones, remainder 5, op_done one edge after start.
REQ-029 The bench SHALL cover: 64'h8000_0000_0000_0000 / 64'hFFFF_FFFF_FFFF_FFFF -> quotient 64'h8000_0000_0000_0000, remainder 0, div_by_zero=0.
REQ-030 The bench SHALL cover: reset_n pulled low 30 edges into EXEC -> all outputs 0 at once, no op_done; after release, 100/7 completes with quotient 14, remainder 2.
REQ-031 The bench SHALL cover: op_clear at edge 40 of EXEC with op_start still high -> outputs stay 0, new operation starts next edge, op_done 65 edges after that.
